// File: rtl/counter8.sv
// counter8: free-running modulo-8 counter driving one 7-segment digit.
// Optional up/down direction input is enabled by defining COUNTER8_DIR_EN.
module counter8 #(
    parameter bit         SEG_ACTIVE_LOW = 1'b1,
    parameter logic [2:0] RESET_VALUE    = 3'd0
) (
    input  logic       CLK,
    input  logic       rst_n,
`ifdef COUNTER8_DIR_EN
    input  logic       iUp,
`endif
    output logic [2:0] oQ,
    output logic [6:0] oDisplay
);

    logic [2:0] count;
    logic [2:0] count_next;
    logic [6:0] seg_on;

    always_comb begin
`ifdef COUNTER8_DIR_EN
        count_next = iUp ? count + 3'd1 : count - 3'd1;
`else
        count_next = count + 3'd1;
`endif
    end

    // NOTE: reset is sampled only on the clock edge, so rst_n is absent from
    // the sensitivity list; state uses non-blocking assignment throughout.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            count <= RESET_VALUE;
        end else begin
            count <= count_next;
        end
    end

    assign oQ = count;

    // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        seg_on = 7'h00;
        case (count)
            3'd0:    seg_on = 7'h3F;
            3'd1:    seg_on = 7'h06;
            3'd2:    seg_on = 7'h5B;
            3'd3:    seg_on = 7'h4F;
            3'd4:    seg_on = 7'h66;
            3'd5:    seg_on = 7'h6D;
            3'd6:    seg_on = 7'h7D;
            3'd7:    seg_on = 7'h07;
            default: seg_on = 7'h00;
        endcase
    end

    // Inversion keeps the X-safe default meaning "all segments dark" for both polarities.
    assign oDisplay = SEG_ACTIVE_LOW ? ~seg_on : seg_on;

endmodule

// File: tb/tb_counter8.sv
// Directed self-checking bench for counter8: one active-low and one
// active-high instance share clock and reset.
module tb_counter8;

    logic       CLK;
    logic       rst_n;
`ifdef COUNTER8_DIR_EN
    logic       iUp;
`endif
    logic [2:0] q_lo;
    logic [6:0] disp_lo;
    logic [2:0] q_hi;
    logic [6:0] disp_hi;

    int vectors    = 0;
    int miscompares = 0;

    // Hand-written decode tables indexed by count.
    logic [6:0] tbl_lo [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    logic [6:0] tbl_hi [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    counter8 #(.SEG_ACTIVE_LOW(1'b1), .RESET_VALUE(3'd0)) dut_lo (
        .CLK      (CLK),
        .rst_n    (rst_n),
`ifdef COUNTER8_DIR_EN
        .iUp      (iUp),
`endif
        .oQ       (q_lo),
        .oDisplay (disp_lo)
    );

    counter8 #(.SEG_ACTIVE_LOW(1'b0), .RESET_VALUE(3'd0)) dut_hi (
        .CLK      (CLK),
        .rst_n    (rst_n),
`ifdef COUNTER8_DIR_EN
        .iUp      (iUp),
`endif
        .oQ       (q_hi),
        .oDisplay (disp_hi)
    );

    initial CLK = 1'b0;
    always #25 CLK = ~CLK;

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compare both instances against the expected count.
    task automatic check_all(input string tag, input int exp_q);
        check({tag, " q_lo"},    {4'b0, q_lo}, 7'(exp_q));
        check({tag, " disp_lo"}, disp_lo,      tbl_lo[exp_q]);
        check({tag, " q_hi"},    {4'b0, q_hi}, 7'(exp_q));
        check({tag, " disp_hi"}, disp_hi,      tbl_hi[exp_q]);
    endtask

    initial begin
        rst_n = 1'b0;
`ifdef COUNTER8_DIR_EN
        iUp = 1'b1;
`endif
        // One reset edge, then release.
        @(negedge CLK);
        @(negedge CLK);
        check_all("reset", 0);
        rst_n = 1'b1;

        // Eight counting edges: 1..7 then wrap to 0.
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            check_all($sformatf("count%0d", i), i % 8);
        end

        // Short low pulse during the high phase with no rising edge inside.
        @(posedge CLK);
        #10 rst_n = 1'b0;
        #1  rst_n = 1'b1;
        @(negedge CLK);
        check_all("no_async", 1);

        @(negedge CLK);
        check_all("pre_rst", 2);

        // Reset mid-count held across two edges, then resume.
        rst_n = 1'b0;
        @(negedge CLK);
        check_all("mid_rst1", 0);
        @(negedge CLK);
        check_all("mid_rst2", 0);
        rst_n = 1'b1;
        @(negedge CLK);
        check_all("resume", 1);

`ifdef COUNTER8_DIR_EN
        rst_n = 1'b0;
        @(negedge CLK);
        check_all("dir_rst", 0);
        rst_n = 1'b1;
        iUp = 1'b0;
        @(negedge CLK); check_all("down7", 7);
        @(negedge CLK); check_all("down6", 6);
        @(negedge CLK); check_all("down5", 5);
        iUp = 1'b1;
        @(negedge CLK); check_all("up6", 6);
        @(negedge CLK); check_all("up7", 7);
        @(negedge CLK); check_all("up0", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter8.md
Name: counter8

Overview:
- 3-bit free-running binary counter, modulo 8 (0→7→0), one step per rising clock edge.
- Drives a single 7-segment digit showing the current count (digits 0–7).
- Sits at board top level as a demo/visual counter.
- Count register and segment decoder are in the same block; no external prescaler is included.

Parameters:
- SEG_ACTIVE_LOW, default 1: 1 = segment bit 0 lights the segment (common-anode board); 0 = segment bit 1 lights the segment.
- RESET_VALUE, default 3'd0: count loaded by reset; legal range 0–7.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  one clock; reset is synchronous and active-low, sampled on the CLK rising edge.
- oQ  output  3  current count value.
- oDisplay  output  7  7-segment pattern for oQ. Bit order is {g,f,e,d,c,b,a}, so bit0 = a and bit6 = g.

Behaviour:
- Reset:
  - If rst_n = 0 at a CLK rising edge, oQ <= RESET_VALUE (0 by default).
  - Reset has priority over counting.
  - No asynchronous path: a low pulse on rst_n that contains no rising edge has no effect.
- Count:
  - If rst_n = 1 at a rising edge, oQ <= oQ + 1, modulo 8.
  - Wrap 7 → 0 with no flag and no stall.
- Latency:
  - oQ changes one clock after the reset/count decision (registered).
  - oDisplay is a purely combinational decode of oQ, with zero additional latency.
  - oDisplay is glitch-tolerant only; it is not registered.
- Reset mid-count: the count returns to RESET_VALUE on the first rising edge with rst_n = 0 and holds there while rst_n stays low. Counting resumes with RESET_VALUE+1 on the first edge with rst_n = 1.
- Decode table, active-high form {g..a}:
  - 0 = 0x3F
  - 1 = 0x06
  - 2 = 0x5B
  - 3 = 0x4F
  - 4 = 0x66
  - 5 = 0x6D
  - 6 = 0x7D
  - 7 = 0x07
- Active-low output (SEG_ACTIVE_LOW = 1) is the bitwise inverse:
  - 0 = 0x40
  - 1 = 0x79
  - 2 = 0x24
  - 3 = 0x30
  - 4 = 0x19
  - 5 = 0x12
  - 6 = 0x02
  - 7 = 0x78
- Before the first reset edge oQ is undefined. The design does not rely on an initial value.
- Decoder default branch: all segments off. It is unreachable for 3-bit oQ but is present for X-safety.

Optional Feature:
- Macro: COUNTER8_DIR_EN.
- When defined:
  - Adds input port iUp (1 bit), placed after rst_n.
  - iUp = 1 counts up (0→7→0); iUp = 0 counts down (7→0→7, i.e. 0 → 7 on underflow).
  - iUp is sampled on the same rising edge as the count.
  - Reset still has priority.
- When undefined:
  - The port does not exist and the block counts up only, exactly as in Behaviour.

Test Plan:
- rst_n = 0 across one rising edge, then high → oQ = 0, oDisplay = 0x40. Next edges give oQ = 1 (0x79), 2 (0x24), 3 (0x30).
- Hold rst_n = 1 for 8 edges from 0 → oQ passes 1..7 and returns to 0 on the 8th edge (7 → 0 wrap). oDisplay matches the active-low table each cycle.
- 50 ns clock; rst_n pulses low for 1 ns with no rising edge inside → oQ unchanged (no asynchronous reset).
- While oQ = 2, drive rst_n low for 50 ns covering one rising edge → oQ = 0 at that edge. The following edge with rst_n = 1 gives oQ = 1.
- SEG_ACTIVE_LOW = 0, count 0..7 → oDisplay = 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07.
- COUNTER8_DIR_EN defined: reset, then iUp = 0 → oQ sequence 7, 6, 5. Switch iUp = 1 → oQ goes 6, 7, 0.
